fpu_addsub_sched: RTL and testbench

Round-robin scheduler that shares one FP32 add/sub unit among N_REQ requesters.
- Captures a granted requester's operands and op, issues a one-cycle start, and holds the unit's inputs stable until it reports ready.
- Returns the result, tagged with the requester index.
- A watchdog aborts operations the unit never completes.
- Sits between the datapath clients and the single add/sub instance.

---
 rtl/fpu_ctrl_pkg.sv | 16 +
 rtl/fpu_addsub_sched_if.sv | 23 ++
 rtl/fpu_addsub_sched_rr_arbiter.sv | 27 ++
 rtl/fpu_addsub_sched.sv | 163 ++++++++++++++++
 tb/tb_fpu_addsub_sched.sv | 439 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fpu_ctrl_pkg.sv
// Shared types and constants for the FP32 add/sub scheduler slice.
package fpu_ctrl_pkg;

    localparam int FP32_W = 32;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } sched_state_e;

endpackage

// File: rtl/fpu_addsub_sched_if.sv
// Connection between the scheduler and the single shared FP32 add/sub unit.
interface fpu_addsub_sched_if;
    import fpu_ctrl_pkg::*;

    logic              fpu_start;
    logic              fpu_op;
    logic [FP32_W-1:0] fpu_a;
    logic [FP32_W-1:0] fpu_b;
    logic              fpu_busy;
    logic              fpu_ready;
    logic [FP32_W-1:0] fpu_data;

    modport master (
        output fpu_start, fpu_op, fpu_a, fpu_b,
        input  fpu_busy, fpu_ready, fpu_data
    );

    modport slave (
        input  fpu_start, fpu_op, fpu_a, fpu_b,
        output fpu_busy, fpu_ready, fpu_data
    );

endinterface

// File: rtl/fpu_addsub_sched_rr_arbiter.sv
// Combinational round-robin pick: first active request at or above the pointer, wrapping.
module rr_arbiter #(
    parameter int N_REQ = 4,
    parameter int IDX_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic [IDX_W-1:0] grant_idx,
    output logic             any_valid
);

    logic [IDX_W-1:0] probe;

    always_comb begin
        grant_idx = '0;
        any_valid = 1'b0;
        probe     = ptr;
        for (int k = 0; k < N_REQ; k++) begin
            if (!any_valid && req[probe]) begin
                any_valid = 1'b1;
                grant_idx = probe;
            end
            probe = (probe == IDX_W'(N_REQ - 1)) ? '0 : probe + 1'b1;
        end
    end

endmodule

// File: rtl/fpu_addsub_sched.sv
// Round-robin scheduler sharing one FP32 add/sub unit among N_REQ requesters, with abort watchdog.
module fpu_addsub_sched
    import fpu_ctrl_pkg::*;
#(
    parameter int N_REQ       = 4,
    parameter int TIMEOUT_CYC = 32,
    parameter int IDX_W       = $clog2(N_REQ)
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [N_REQ-1:0]        req_valid,
    input  logic [N_REQ-1:0]        req_op,
    input  logic [FP32_W*N_REQ-1:0] req_a,
    input  logic [FP32_W*N_REQ-1:0] req_b,
    output logic [N_REQ-1:0]        req_ack,
    output logic                    rsp_valid,
    output logic [IDX_W-1:0]        rsp_id,
    output logic [FP32_W-1:0]       rsp_data,
    output logic                    rsp_err,
    output logic                    sched_busy,
    output logic [7:0]              timeout_cnt,
    fpu_addsub_sched_if.master      fpu
);

    localparam int WD_W = $clog2(TIMEOUT_CYC);

    logic [N_REQ-1:0][FP32_W-1:0] req_a_arr;
    logic [N_REQ-1:0][FP32_W-1:0] req_b_arr;
    logic [IDX_W-1:0]             grant_idx;
    logic                         any_valid;
    logic                         unused_busy;

    sched_state_e      state_q, state_d;
    logic [IDX_W-1:0]  ptr_q, ptr_d, idx_q, idx_d, rsp_id_q, rsp_id_d;
    logic              op_q, op_d, fpu_start_q, fpu_start_d;
    logic [FP32_W-1:0] a_q, a_d, b_q, b_d, rsp_data_q, rsp_data_d;
    logic [WD_W-1:0]   wd_q, wd_d;
    logic [N_REQ-1:0]  req_ack_q, req_ack_d;
    logic              rsp_valid_q, rsp_valid_d, rsp_err_q, rsp_err_d;
    logic              sched_busy_q, sched_busy_d;
    logic [7:0]        timeout_cnt_q, timeout_cnt_d;

    assign req_a_arr   = req_a;
    assign req_b_arr   = req_b;
    assign unused_busy = fpu.fpu_busy;

    rr_arbiter #(.N_REQ(N_REQ), .IDX_W(IDX_W)) u_arb (
        .req       (req_valid),
        .ptr       (ptr_q),
        .grant_idx (grant_idx),
        .any_valid (any_valid)
    );

    // Holding regs drive the unit directly so its operands stay frozen until the result returns.
    always_comb begin
        state_d       = state_q;
        ptr_d         = ptr_q;
        idx_d         = idx_q;
        op_d          = op_q;
        a_d           = a_q;
        b_d           = b_q;
        wd_d          = wd_q;
        req_ack_d     = '0;
        fpu_start_d   = 1'b0;
        rsp_valid_d   = 1'b0;
        rsp_id_d      = rsp_id_q;
        rsp_data_d    = rsp_data_q;
        rsp_err_d     = rsp_err_q;
        timeout_cnt_d = timeout_cnt_q;
        case (state_q)
            IDLE: begin
                if (any_valid) begin
                    idx_d                = grant_idx;
                    op_d                 = req_op[grant_idx];
                    a_d                  = req_a_arr[grant_idx];
                    b_d                  = req_b_arr[grant_idx];
                    req_ack_d[grant_idx] = 1'b1;
                    fpu_start_d          = 1'b1;
                    state_d              = ISSUE;
                end
            end
            ISSUE: begin
                wd_d    = '0;
                state_d = WAIT;
            end
            WAIT: begin
                if (fpu.fpu_ready) begin
                    rsp_data_d  = fpu.fpu_data;
                    rsp_err_d   = 1'b0;
                    rsp_id_d    = idx_q;
                    rsp_valid_d = 1'b1;
                    state_d     = DONE;
                end else if (wd_q == WD_W'(TIMEOUT_CYC - 1)) begin
                    rsp_data_d  = '0;
                    rsp_err_d   = 1'b1;
                    rsp_id_d    = idx_q;
                    rsp_valid_d = 1'b1;
                    state_d     = DONE;
                    if (timeout_cnt_q != 8'hFF) begin
                        timeout_cnt_d = timeout_cnt_q + 8'd1;
                    end
                end else begin
                    wd_d = wd_q + 1'b1;
                end
            end
            DONE: begin
                ptr_d   = (idx_q == IDX_W'(N_REQ - 1)) ? '0 : idx_q + 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        sched_busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            ptr_q         <= '0;
            idx_q         <= '0;
            op_q          <= 1'b0;
            a_q           <= '0;
            b_q           <= '0;
            wd_q          <= '0;
            req_ack_q     <= '0;
            fpu_start_q   <= 1'b0;
            rsp_valid_q   <= 1'b0;
            rsp_id_q      <= '0;
            rsp_data_q    <= '0;
            rsp_err_q     <= 1'b0;
            sched_busy_q  <= 1'b0;
            timeout_cnt_q <= '0;
        end else begin
            state_q       <= state_d;
            ptr_q         <= ptr_d;
            idx_q         <= idx_d;
            op_q          <= op_d;
            a_q           <= a_d;
            b_q           <= b_d;
            wd_q          <= wd_d;
            req_ack_q     <= req_ack_d;
            fpu_start_q   <= fpu_start_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_id_q      <= rsp_id_d;
            rsp_data_q    <= rsp_data_d;
            rsp_err_q     <= rsp_err_d;
            sched_busy_q  <= sched_busy_d;
            timeout_cnt_q <= timeout_cnt_d;
        end
    end

    assign req_ack       = req_ack_q;
    assign rsp_valid     = rsp_valid_q;
    assign rsp_id        = rsp_id_q;
    assign rsp_data      = rsp_data_q;
    assign rsp_err       = rsp_err_q;
    assign sched_busy    = sched_busy_q;
    assign timeout_cnt   = timeout_cnt_q;
    assign fpu.fpu_start = fpu_start_q;
    assign fpu.fpu_op    = op_q;
    assign fpu.fpu_a     = a_q;
    assign fpu.fpu_b     = b_q;

endmodule

// File: tb/tb_fpu_addsub_sched.sv
// Directed bench for fpu_addsub_sched with a behavioural add/sub unit of configurable latency.
module tb_fpu_addsub_sched;
    import fpu_ctrl_pkg::*;

    localparam int N_REQ       = 4;
    localparam int TIMEOUT_CYC = 16;
    localparam int IDX_W       = 2;

    logic                     clock = 1'b0;
    logic                     reset = 1'b1;
    logic [N_REQ-1:0]         req_valid = '0;
    logic [N_REQ-1:0]         req_op = '0;
    logic [32*N_REQ-1:0]      req_a = '0;
    logic [32*N_REQ-1:0]      req_b = '0;
    logic [N_REQ-1:0]         req_ack;
    logic                     rsp_valid, rsp_err, sched_busy;
    logic [IDX_W-1:0]         rsp_id;
    logic [31:0]              rsp_data;
    logic [7:0]               timeout_cnt;

    int tests_run    = 0;
    int tests_failed = 0;
    int cyc          = 0;

    // Unit model: latency 0 means it never answers; otherwise a one-cycle ready pulse.
    int          model_lat = 5;
    logic        model_fixed_en = 1'b0;
    logic [31:0] model_fixed = '0;
    logic        m_busy = 1'b0, m_ready = 1'b0, m_unstable = 1'b0, cap_op = 1'b0;
    int          m_cnt = 0, ready_cyc = -100;
    logic [31:0] cap_a = '0, cap_b = '0, m_data = '0;
    logic        force_ready = 1'b0;
    logic [31:0] force_data = '0;

    int          ops_left [4];
    int          exp_order [8];
    int          n_ops;

    fpu_addsub_sched_if fpu_bus ();

    assign fpu_bus.fpu_ready = m_ready | force_ready;
    assign fpu_bus.fpu_data  = force_ready ? force_data : m_data;
    assign fpu_bus.fpu_busy  = m_busy;

    fpu_addsub_sched #(.N_REQ(N_REQ), .TIMEOUT_CYC(TIMEOUT_CYC)) dut (
        .clock       (clock),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_op      (req_op),
        .req_a       (req_a),
        .req_b       (req_b),
        .req_ack     (req_ack),
        .rsp_valid   (rsp_valid),
        .rsp_id      (rsp_id),
        .rsp_data    (rsp_data),
        .rsp_err     (rsp_err),
        .sched_busy  (sched_busy),
        .timeout_cnt (timeout_cnt),
        .fpu         (fpu_bus.master)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    always @(negedge clock) begin
        if (reset) begin
            m_busy  = 1'b0;
            m_ready = 1'b0;
        end else begin
            m_ready = 1'b0;
            if (m_busy) begin
                if (fpu_bus.fpu_a !== cap_a || fpu_bus.fpu_b !== cap_b || fpu_bus.fpu_op !== cap_op)
                    m_unstable = 1'b1;
                m_cnt = m_cnt - 1;
                if (m_cnt == 0) begin
                    m_ready   = 1'b1;
                    m_data    = model_fixed_en ? model_fixed : cap_a + cap_b;
                    m_busy    = 1'b0;
                    ready_cyc = cyc;
                end
            end else if (fpu_bus.fpu_start) begin
                cap_a      = fpu_bus.fpu_a;
                cap_b      = fpu_bus.fpu_b;
                cap_op     = fpu_bus.fpu_op;
                m_unstable = 1'b0;
                if (model_lat > 0) begin
                    m_busy = 1'b1;
                    m_cnt  = model_lat;
                end
            end
        end
    end

    function automatic logic [31:0] opa(int i, int n);
        return 32'h0100_0000 * (i + 1) + 32'(n);
    endfunction

    function automatic logic [31:0] opb(int i, int n);
        return 32'h0000_0100 * (n + 1) + 32'(i);
    endfunction

    task automatic do_reset;
        @(negedge clock);
        reset       = 1'b1;
        req_valid   = '0;
        force_ready = 1'b0;
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic test_reset;
        @(negedge clock);
        tests_run++;
        if ({req_ack, rsp_valid, rsp_err, sched_busy, fpu_bus.fpu_start, fpu_bus.fpu_op} !== '0) begin
            tests_failed++;
            $display("[TB] FAIL reset_ctrl: got %b expected 0",
                     {req_ack, rsp_valid, rsp_err, sched_busy, fpu_bus.fpu_start, fpu_bus.fpu_op});
        end
        tests_run++;
        if ({rsp_data, rsp_id} !== '0) begin
            tests_failed++;
            $display("[TB] FAIL reset_rsp: got %h expected 0", {rsp_data, rsp_id});
        end
        tests_run++;
        if ({fpu_bus.fpu_a, fpu_bus.fpu_b, timeout_cnt} !== '0) begin
            tests_failed++;
            $display("[TB] FAIL reset_fpu: got %h expected 0", {fpu_bus.fpu_a, fpu_bus.fpu_b, timeout_cnt});
        end
        reset = 1'b0;
    endtask

    task automatic test_single;
        int t, starts;
        logic got;
        do_reset();
        model_lat = 5; model_fixed_en = 1'b1; model_fixed = 32'h4040_0000;
        @(negedge clock);
        req_valid = 4'b0001; req_op[0] = OP_ADD;
        req_a[31:0] = 32'h3F80_0000; req_b[31:0] = 32'h4000_0000;
        t = cyc;
        @(negedge clock);
        tests_run++;
        if (req_ack !== 4'b0001 || cyc != t + 1) begin
            tests_failed++;
            $display("[TB] FAIL single_ack: got ack %b at cycle %0d expected 0001 at %0d", req_ack, cyc, t + 1);
        end
        tests_run++;
        if ({fpu_bus.fpu_start, fpu_bus.fpu_op, fpu_bus.fpu_a, fpu_bus.fpu_b} !== {2'b10, 32'h3F80_0000, 32'h4000_0000}) begin
            tests_failed++;
            $display("[TB] FAIL single_issue: got start=%b a=%h b=%h expected start=1 a=3f800000 b=40000000",
                     fpu_bus.fpu_start, fpu_bus.fpu_a, fpu_bus.fpu_b);
        end
        req_valid = '0;
        starts = 1; got = 1'b0;
        for (int c = 0; c < 40 && !got; c++) begin
            @(negedge clock);
            if (fpu_bus.fpu_start) starts++;
            if (rsp_valid) got = 1'b1;
        end
        tests_run++;
        if (!got || cyc != ready_cyc + 1) begin
            tests_failed++;
            $display("[TB] FAIL single_latency: got rsp=%b at cycle %0d expected at %0d", got, cyc, ready_cyc + 1);
        end
        tests_run++;
        if ({rsp_id, rsp_err, rsp_data} !== {2'd0, 1'b0, 32'h4040_0000}) begin
            tests_failed++;
            $display("[TB] FAIL single_rsp: got id=%0d err=%b data=%h expected id=0 err=0 data=40400000",
                     rsp_id, rsp_err, rsp_data);
        end
        tests_run++;
        if (starts != 1 || m_unstable !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL single_start_stable: got starts=%0d unstable=%b expected 1 and 0", starts, m_unstable);
        end
        @(negedge clock);
        tests_run++;
        if ({rsp_valid, sched_busy, rsp_data} !== {2'b00, 32'h4040_0000}) begin
            tests_failed++;
            $display("[TB] FAIL single_after: got valid=%b busy=%b data=%h expected 0 0 40400000",
                     rsp_valid, sched_busy, rsp_data);
        end
        model_fixed_en = 1'b0;
    endtask

    task automatic run_fairness(input string name);
        int sent [4];
        int g, r, idle_run, idx;
        logic started;
        int exp_id_q [$];
        logic [31:0] exp_data_q [$];
        g = 0; r = 0; idle_run = 0; started = 1'b0;
        do_reset();
        model_lat = 2;
        @(negedge clock);
        for (int i = 0; i < 4; i++) begin
            sent[i] = 0;
            if (ops_left[i] > 0) begin
                req_valid[i] = 1'b1; req_op[i] = 1'b0;
                req_a[32*i +: 32] = opa(i, 0); req_b[32*i +: 32] = opb(i, 0);
            end
        end
        for (int c = 0; c < 400 && r < n_ops; c++) begin
            @(negedge clock);
            if (rsp_valid) begin
                tests_run++;
                if (exp_id_q.size() == 0) begin
                    tests_failed++;
                    $display("[TB] FAIL %s_spurious_rsp: got id=%0d expected no response", name, rsp_id);
                end else if (rsp_id !== IDX_W'(exp_id_q[0]) || rsp_data !== exp_data_q[0] || rsp_err !== 1'b0) begin
                    tests_failed++;
                    $display("[TB] FAIL %s_rsp: got id=%0d data=%h err=%b expected id=%0d data=%h err=0",
                             name, rsp_id, rsp_data, rsp_err, exp_id_q[0], exp_data_q[0]);
                end
                if (exp_id_q.size() != 0) begin
                    void'(exp_id_q.pop_front());
                    void'(exp_data_q.pop_front());
                end
                r++;
            end
            if (req_ack != '0) begin
                idx = 0;
                for (int i = 0; i < 4; i++) if (req_ack[i]) idx = i;
                tests_run++;
                if (!$onehot(req_ack) || g >= n_ops || idx != exp_order[g % 8]) begin
                    tests_failed++;
                    $display("[TB] FAIL %s_grant%0d: got ack %b expected requester %0d", name, g, req_ack, exp_order[g % 8]);
                end
                exp_id_q.push_back(idx);
                exp_data_q.push_back(opa(idx, sent[idx]) + opb(idx, sent[idx]));
                sent[idx]++; g++;
                if (sent[idx] < ops_left[idx]) begin
                    req_op[idx] = sent[idx][0];
                    req_a[32*idx +: 32] = opa(idx, sent[idx]); req_b[32*idx +: 32] = opb(idx, sent[idx]);
                end else begin
                    req_valid[idx] = 1'b0;
                end
                if (started) begin
                    tests_run++;
                    if (idle_run != 1) begin
                        tests_failed++;
                        $display("[TB] FAIL %s_idle_gap: got %0d idle cycles expected 1", name, idle_run);
                    end
                end
                started = 1'b1; idle_run = 0;
            end else if (!sched_busy) begin
                idle_run++;
            end
        end
        tests_run++;
        if (r != n_ops || g != n_ops) begin
            tests_failed++;
            $display("[TB] FAIL %s_count: got %0d grants %0d responses expected %0d", name, g, r, n_ops);
        end
        req_valid = '0;
    endtask

    task automatic test_two_requesters;
        ops_left = '{2, 0, 2, 0};
        exp_order = '{0, 2, 0, 2, 0, 0, 0, 0};
        n_ops = 4;
        run_fairness("two_req");
    endtask

    task automatic test_back_to_back;
        ops_left = '{2, 1, 1, 1};
        exp_order = '{0, 1, 2, 3, 0, 0, 0, 0};
        n_ops = 5;
        run_fairness("all_req");
    endtask

    task automatic test_timeout;
        int s;
        logic got;
        do_reset();
        model_lat = 0;
        @(negedge clock);
        req_valid = 4'b0010; req_a[63:32] = 32'hAAAA_0001; req_b[63:32] = 32'h5555_0002;
        @(negedge clock);
        s = cyc; req_valid = '0;
        got = 1'b0;
        for (int c = 0; c < 60 && !got; c++) begin
            @(negedge clock);
            if (rsp_valid) got = 1'b1;
        end
        tests_run++;
        if (!got || cyc != s + TIMEOUT_CYC + 1) begin
            tests_failed++;
            $display("[TB] FAIL timeout_time: got rsp=%b at cycle %0d expected at %0d", got, cyc, s + TIMEOUT_CYC + 1);
        end
        tests_run++;
        if ({rsp_err, rsp_data, rsp_id, timeout_cnt} !== {1'b1, 32'h0, 2'd1, 8'd1}) begin
            tests_failed++;
            $display("[TB] FAIL timeout_rsp: got err=%b data=%h id=%0d cnt=%0d expected 1 0 1 1",
                     rsp_err, rsp_data, rsp_id, timeout_cnt);
        end
        model_lat = 3;
        @(negedge clock);
        req_valid = 4'b1000; req_a[127:96] = 32'h3F80_0000; req_b[127:96] = 32'h3F80_0000;
        @(negedge clock);
        req_valid = '0; got = 1'b0;
        for (int c = 0; c < 40 && !got; c++) begin
            @(negedge clock);
            if (rsp_valid) got = 1'b1;
        end
        tests_run++;
        if ({got, rsp_err, rsp_data, rsp_id, timeout_cnt} !== {2'b10, 32'h7F00_0000, 2'd3, 8'd1}) begin
            tests_failed++;
            $display("[TB] FAIL timeout_recover: got rsp=%b err=%b data=%h id=%0d cnt=%0d expected 1 0 7f000000 3 1",
                     got, rsp_err, rsp_data, rsp_id, timeout_cnt);
        end
    endtask

    task automatic test_ready_ignored;
        int s, early;
        do_reset();
        model_lat = 0;
        @(negedge clock);
        force_ready = 1'b1; force_data = 32'hDEAD_BEEF;
        @(negedge clock);
        force_ready = 1'b0;
        tests_run++;
        if ({rsp_valid, sched_busy, rsp_data} !== {2'b00, 32'h0}) begin
            tests_failed++;
            $display("[TB] FAIL ready_in_idle: got valid=%b busy=%b data=%h expected 0 0 0", rsp_valid, sched_busy, rsp_data);
        end
        req_valid = 4'b0001; req_a[31:0] = 32'h1111_1111; req_b[31:0] = 32'h2222_2222;
        @(negedge clock);
        s = cyc; req_valid = '0;
        force_ready = 1'b1; force_data = 32'hDEAD_BEEF;
        @(negedge clock);
        force_ready = 1'b0;
        tests_run++;
        if (rsp_valid !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL ready_in_issue: got rsp_valid=%b expected 0", rsp_valid);
        end
        early = 0;
        for (int c = 0; c < 40 && cyc < s + TIMEOUT_CYC; c++) begin
            @(negedge clock);
            if (rsp_valid) early++;
        end
        force_ready = 1'b1; force_data = 32'h1234_5678;
        @(negedge clock);
        force_ready = 1'b0;
        tests_run++;
        if (early != 0 || cyc != s + TIMEOUT_CYC + 1 || rsp_valid !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL ready_last_cycle_time: got early=%0d valid=%b cycle %0d expected 0 1 %0d",
                     early, rsp_valid, cyc, s + TIMEOUT_CYC + 1);
        end
        tests_run++;
        if ({rsp_err, rsp_data, timeout_cnt} !== {1'b0, 32'h1234_5678, 8'd0}) begin
            tests_failed++;
            $display("[TB] FAIL ready_last_cycle_rsp: got err=%b data=%h cnt=%0d expected 0 12345678 0",
                     rsp_err, rsp_data, timeout_cnt);
        end
    endtask

    task automatic test_reset_mid_wait;
        int seen;
        logic got;
        do_reset();
        model_lat = 0;
        @(negedge clock);
        req_valid = 4'b0100; req_a[95:64] = 32'hCAFE_0000; req_b[95:64] = 32'h0000_BABE;
        @(negedge clock);
        req_valid = '0;
        repeat (4) @(negedge clock);
        tests_run++;
        if (sched_busy !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL midwait_busy: got %b expected 1", sched_busy);
        end
        #2 reset = 1'b1;
        #1;
        tests_run++;
        if ({req_ack, rsp_valid, rsp_err, sched_busy, fpu_bus.fpu_start, fpu_bus.fpu_op,
             fpu_bus.fpu_a, fpu_bus.fpu_b, timeout_cnt} !== '0) begin
            tests_failed++;
            $display("[TB] FAIL midwait_async_reset: got busy=%b a=%h b=%h expected all zero",
                     sched_busy, fpu_bus.fpu_a, fpu_bus.fpu_b);
        end
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
        seen = 0;
        repeat (25) begin
            @(negedge clock);
            if (rsp_valid) seen++;
        end
        tests_run++;
        if (seen != 0) begin
            tests_failed++;
            $display("[TB] FAIL midwait_no_rsp: got %0d responses expected 0", seen);
        end
        model_lat = 2;
        req_valid = 4'b1010;
        req_a[63:32] = 32'h0000_0010; req_b[63:32] = 32'h0000_0020;
        req_a[127:96] = 32'h0000_0030; req_b[127:96] = 32'h0000_0040;
        @(negedge clock);
        tests_run++;
        if (req_ack !== 4'b0010) begin
            tests_failed++;
            $display("[TB] FAIL midwait_ptr: got ack %b expected 0010", req_ack);
        end
        req_valid = '0; got = 1'b0;
        for (int c = 0; c < 40 && !got; c++) begin
            @(negedge clock);
            if (rsp_valid) got = 1'b1;
        end
        tests_run++;
        if ({got, rsp_id, rsp_err, rsp_data} !== {1'b1, 2'd1, 1'b0, 32'h0000_0030}) begin
            tests_failed++;
            $display("[TB] FAIL midwait_next: got rsp=%b id=%0d err=%b data=%h expected 1 1 0 00000030",
                     got, rsp_id, rsp_err, rsp_data);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_two_requesters();
        test_back_to_back();
        test_timeout();
        test_ready_ignored();
        test_reset_mid_wait();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL global_timeout: simulation did not finish within 200000 time units");
        $fatal(1, "[TB] bench stalled");
    end

endmodule
